// File: rtl/timer_pkg.sv
// Shared definitions for the interval timer controller.
//   state_t       : controller FSM state encoding (ST_IDLE, ST_RUN, ST_DONE)
//   MODE_ONESHOT  : stop in DONE with the count held at all ones after expiry
//   MODE_RELOAD   : reload the shadow Reload value on expiry and keep running
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/counter_stage4.sv
// 4-bit synchronous loadable up-counter stage, cascadable by ripple carry.
//   clk_i  : clock, rising edge
//   clr_i  : asynchronous active-high clear
//   load_i : synchronous parallel load of d_i (wins over counting)
//   d_i    : parallel load data
//   ent_i  : enable-trickle; also gates rco_o
//   enp_i  : enable-parallel
//   q_o    : stage count
//   rco_o  : ripple carry out, high when ent_i is high and the stage is all ones
module counter_stage4 (
  input  logic       clk_i,
  input  logic       clr_i,
  input  logic       load_i,
  input  logic [3:0] d_i,
  input  logic       ent_i,
  input  logic       enp_i,
  output logic [3:0] q_o,
  output logic       rco_o
);

  logic [3:0] q_q, q_d;

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) q_q <= 4'h0;
    else       q_q <= q_d;
  end

  always_comb begin
    q_d = q_q;
    if (load_i)              q_d = d_i;
    else if (ent_i && enp_i) q_d = q_q + 4'd1;
  end

  assign q_o   = q_q;
  assign rco_o = ent_i & (&q_q);

endmodule

// File: rtl/ttl_timer_ctrl.sv
// Programmable interval timer controller built on a cascade of 4-bit counter
// stages. Start captures Reload/Prescale/Mode into shadow registers and loads
// the chain; the prescaler then paces count enables into the chain, and the
// last stage's carry is the terminal-count Tick that latches Irq.
//   Clk      : clock, rising edge
//   Clear    : asynchronous active-high reset
//   Start    : (re)arm: load Reload, capture shadows, enter RUN
//   Stop     : halt from RUN to IDLE, count holds; wins over Start
//   Mode     : 0 one-shot, 1 auto-reload (captured at Start)
//   Reload   : initial / reload count (captured at Start)
//   Prescale : count enable every Prescale+1 cycles (captured at Start)
//   Irq_ack  : clears Irq and Overrun
//   Q        : current count
//   Busy     : high in RUN
//   Tick     : combinational terminal-count pulse
//   Irq      : latched expiry interrupt
//   Overrun  : expiry seen while Irq was still pending
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | stopped or never started; count holds
// ST_RUN  | prescaler running, chain counting on enables
// ST_DONE | one-shot expired; count held at all ones
module ttl_timer_ctrl
  import timer_pkg::*;
#(
  parameter int STAGES         = 4,
  parameter int PRESCALE_WIDTH = 4
) (
  input  logic                      Clk,
  input  logic                      Clear,
  input  logic                      Start,
  input  logic                      Stop,
  input  logic                      Mode,
  input  logic [4*STAGES-1:0]       Reload,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      Irq_ack,
  output logic [4*STAGES-1:0]       Q,
  output logic                      Busy,
  output logic                      Tick,
  output logic                      Irq,
  output logic                      Overrun
);

  localparam int W = 4 * STAGES;

  state_t                    state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic [PRESCALE_WIDTH-1:0] sh_presc_q, sh_presc_d;
  logic [W-1:0]              sh_reload_q, sh_reload_d;
  logic                      sh_mode_q, sh_mode_d;
  logic                      irq_q, irq_d;
  logic                      ovr_q, ovr_d;

  logic         start_load;
  logic         in_run;
  logic         en;
  logic         tc;
  logic         expire_oneshot;
  logic         reload_tc;
  logic         chain_load;
  logic         cnt_en;
  logic [W-1:0] chain_data;
  logic         carry [STAGES+1];

  // Stop has priority: a simultaneous Start is dropped entirely.
  assign start_load = Start & ~Stop;
  assign in_run     = (state_q == ST_RUN);
  assign en         = in_run & (presc_q == sh_presc_q);

  // The prescaler enable enters the trickle input of stage 0, so the last
  // carry is exactly RUN & en & (Q == all ones).
  assign carry[0] = en;
  assign tc       = carry[STAGES];

  assign expire_oneshot = tc & (sh_mode_q == MODE_ONESHOT);
  assign reload_tc      = tc & (sh_mode_q == MODE_RELOAD) & ~Stop;
  assign chain_load     = start_load | reload_tc;
  assign chain_data     = start_load ? Reload : sh_reload_q;

  // One-shot expiry must not wrap to zero, and Stop freezes the count.
  assign cnt_en = en & ~Stop & ~expire_oneshot;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    counter_stage4 u_stage (
      .clk_i  (Clk),
      .clr_i  (Clear),
      .load_i (chain_load),
      .d_i    (chain_data[4*i +: 4]),
      .ent_i  (carry[i]),
      .enp_i  (cnt_en),
      .q_o    (Q[4*i +: 4]),
      .rco_o  (carry[i+1])
    );
  end

  always_ff @(posedge Clk or posedge Clear) begin
    if (Clear) begin
      state_q     <= ST_IDLE;
      presc_q     <= '0;
      sh_presc_q  <= '0;
      sh_reload_q <= '0;
      sh_mode_q   <= MODE_ONESHOT;
      irq_q       <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      sh_presc_q  <= sh_presc_d;
      sh_reload_q <= sh_reload_d;
      sh_mode_q   <= sh_mode_d;
      irq_q       <= irq_d;
      ovr_q       <= ovr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    sh_presc_d  = sh_presc_q;
    sh_reload_d = sh_reload_q;
    sh_mode_d   = sh_mode_q;

    if (start_load) begin
      state_d     = ST_RUN;
      presc_d     = '0;
      sh_presc_d  = Prescale;
      sh_reload_d = Reload;
      sh_mode_d   = Mode;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_RUN: begin
          if (Stop) begin
            state_d = ST_IDLE;
          end else begin
            if (expire_oneshot) state_d = ST_DONE;
            presc_d = en ? '0 : presc_q + PRESCALE_WIDTH'(1);
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Set wins over acknowledge; Overrun only sets against an un-acked Irq.
  always_comb begin
    irq_d = irq_q;
    ovr_d = ovr_q;
    if (tc)           irq_d = 1'b1;
    else if (Irq_ack) irq_d = 1'b0;
    if (tc && irq_q && !Irq_ack) ovr_d = 1'b1;
    else if (Irq_ack)            ovr_d = 1'b0;
  end

  assign Busy    = in_run;
  assign Tick    = tc;
  assign Irq     = irq_q;
  assign Overrun = ovr_q;

endmodule

// File: tb/tb_ttl_timer_ctrl.sv
module tb_ttl_timer_ctrl;

  logic       Clk = 1'b0;
  logic       Clear, Start, Stop, Mode, Irq_ack;
  logic [3:0] Prescale;
  logic [3:0] reload1;
  logic [7:0] reload2;

  logic [3:0] q1;
  logic       busy1, tick1, irq1, ovr1;
  logic [7:0] q2;
  logic       busy2, tick2, irq2, ovr2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 Clk = ~Clk;

  ttl_timer_ctrl #(.STAGES(1), .PRESCALE_WIDTH(4)) dut1 (
    .Clk(Clk), .Clear(Clear), .Start(Start), .Stop(Stop), .Mode(Mode),
    .Reload(reload1), .Prescale(Prescale), .Irq_ack(Irq_ack),
    .Q(q1), .Busy(busy1), .Tick(tick1), .Irq(irq1), .Overrun(ovr1)
  );

  ttl_timer_ctrl #(.STAGES(2), .PRESCALE_WIDTH(4)) dut2 (
    .Clk(Clk), .Clear(Clear), .Start(Start), .Stop(Stop), .Mode(Mode),
    .Reload(reload2), .Prescale(Prescale), .Irq_ack(Irq_ack),
    .Q(q2), .Busy(busy2), .Tick(tick2), .Irq(irq2), .Overrun(ovr2)
  );

  // Reference model: count derived from cycles elapsed since Start.
  // m_state: 0 idle, 1 running, 2 expired one-shot
  int m_state [2];
  int m_n     [2];
  int m_r     [2];
  int m_p     [2];
  int m_mode  [2];
  int m_hold  [2];
  bit m_irq   [2];
  bit m_ovr   [2];
  int maxv    [2] = '{15, 255};

  function automatic int exp_q(int d);
    int len;
    if (m_state[d] != 1) return m_hold[d];
    if (m_mode[d] == 1) begin
      len = (maxv[d] + 1 - m_r[d]) * (m_p[d] + 1);
      return m_r[d] + (m_n[d] % len) / (m_p[d] + 1);
    end
    return m_r[d] + m_n[d] / (m_p[d] + 1);
  endfunction

  function automatic bit exp_tick(int d);
    return (m_state[d] == 1) && (((m_n[d] + 1) % (m_p[d] + 1)) == 0) && (exp_q(d) == maxv[d]);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_state[d] = 0; m_n[d] = 0; m_r[d] = 0; m_p[d] = 0;
      m_mode[d] = 0; m_hold[d] = 0; m_irq[d] = 0; m_ovr[d] = 0;
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      bit t, irq_old;
      int qn;
      t = exp_tick(d);
      qn = exp_q(d);
      irq_old = m_irq[d];
      if (t) m_irq[d] = 1; else if (Irq_ack) m_irq[d] = 0;
      if (t && irq_old && !Irq_ack) m_ovr[d] = 1; else if (Irq_ack) m_ovr[d] = 0;
      if (Start && !Stop) begin
        m_r[d] = (d == 0) ? int'(reload1) : int'(reload2);
        m_p[d] = int'(Prescale);
        m_mode[d] = int'(Mode);
        m_n[d] = 0;
        m_state[d] = 1;
      end else if (m_state[d] == 1) begin
        if (Stop) begin
          m_state[d] = 0; m_hold[d] = qn;
        end else if (t && m_mode[d] == 0) begin
          m_state[d] = 2; m_hold[d] = maxv[d];
        end else begin
          m_n[d]++;
        end
      end
    end
  endtask

  task automatic advance();
    @(posedge Clk);
    if (Clear) model_reset(); else model_edge();
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Clear = 1'b1; Start = 0; Stop = 0; Mode = 0; Irq_ack = 0;
    Prescale = 4'h0; reload1 = 4'h7; reload2 = 8'h77;
    model_reset();
    #1;
    n_checks++; if (q1 !== 4'h0) $display("FAIL reset_q1: got %h want 0", q1); else n_pass++;
    n_checks++; if (q2 !== 8'h00) $display("FAIL reset_q2: got %h want 00", q2); else n_pass++;
    @(negedge Clk); @(negedge Clk);
    n_checks++; if ({busy1, tick1, irq1, ovr1} !== 4'b0000) $display("FAIL reset_flags1: got %b want 0000", {busy1, tick1, irq1, ovr1}); else n_pass++;
    n_checks++; if ({busy2, tick2, irq2, ovr2} !== 4'b0000) $display("FAIL reset_flags2: got %b want 0000", {busy2, tick2, irq2, ovr2}); else n_pass++;
    Clear = 1'b0;
    advance();
    advance();
    n_checks++; if (q1 !== 4'h0 || busy1 !== 1'b0) $display("FAIL reset_idle_hold: got q=%h busy=%b want q=0 busy=0", q1, busy1); else n_pass++;
  endtask

  task automatic test_oneshot();
    logic [3:0] seq [4];
    seq = '{4'hC, 4'hD, 4'hE, 4'hF};
    reload1 = 4'hC; reload2 = 8'hFC; Prescale = 4'h0; Mode = 1'b0;
    Start = 1'b1;
    advance();
    Start = 1'b0;
    n_checks++; if (busy1 !== 1'b1) $display("FAIL oneshot_busy: got %b want 1", busy1); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (q1 !== seq[i]) $display("FAIL oneshot_q[%0d]: got %h want %h", i, q1, seq[i]); else n_pass++;
      n_checks++; if (tick1 !== (i == 3)) $display("FAIL oneshot_tick[%0d]: got %b want %b", i, tick1, i == 3); else n_pass++;
      n_checks++; if (irq1 !== 1'b0) $display("FAIL oneshot_irq_early[%0d]: got %b want 0", i, irq1); else n_pass++;
      advance();
    end
    n_checks++; if ({irq1, busy1, q1} !== {1'b1, 1'b0, 4'hF}) $display("FAIL oneshot_expire: got irq=%b busy=%b q=%h want irq=1 busy=0 q=f", irq1, busy1, q1); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      advance();
      n_checks++; if (q1 !== 4'hF || tick1 !== 1'b0) $display("FAIL oneshot_hold[%0d]: got q=%h tick=%b want q=f tick=0", i, q1, tick1); else n_pass++;
    end
  endtask

  task automatic test_autoreload();
    Irq_ack = 1'b1;
    advance();
    Irq_ack = 1'b0;
    reload1 = 4'hE; reload2 = 8'hF0; Prescale = 4'h1; Mode = 1'b1;
    Start = 1'b1;
    advance();
    Start = 1'b0;
    // Each value is held two cycles; expiry every fourth cycle.
    for (int n = 0; n < 16; n++) begin
      logic [3:0] want_q;
      want_q = ((n / 2) % 2 == 1) ? 4'hF : 4'hE;
      n_checks++; if (q1 !== want_q) $display("FAIL reload_q[%0d]: got %h want %h", n, q1, want_q); else n_pass++;
      n_checks++; if (tick1 !== (n % 4 == 3)) $display("FAIL reload_tick[%0d]: got %b want %b", n, tick1, n % 4 == 3); else n_pass++;
      advance();
    end
    n_checks++; if (busy1 !== 1'b1) $display("FAIL reload_busy: got %b want 1", busy1); else n_pass++;
  endtask

  task automatic test_irq_ack();
    if (tick1 === 1'b1) advance();
    Irq_ack = 1'b1;
    advance();
    Irq_ack = 1'b0;
    n_checks++; if ({irq1, ovr1} !== 2'b00) $display("FAIL ack_clear: got irq=%b ovr=%b want 0 0", irq1, ovr1); else n_pass++;
    for (int i = 0; i < 20 && tick1 !== 1'b1; i++) advance();
    n_checks++; if (tick1 !== 1'b1) $display("FAIL ack_wait_tick1: got %b want 1 (timeout)", tick1); else n_pass++;
    advance();
    n_checks++; if ({irq1, ovr1} !== 2'b10) $display("FAIL ack_first_expiry: got irq=%b ovr=%b want 1 0", irq1, ovr1); else n_pass++;
    for (int i = 0; i < 20 && tick1 !== 1'b1; i++) advance();
    n_checks++; if (tick1 !== 1'b1) $display("FAIL ack_wait_tick2: got %b want 1 (timeout)", tick1); else n_pass++;
    Irq_ack = 1'b1;
    advance();
    Irq_ack = 1'b0;
    n_checks++; if ({irq1, ovr1} !== 2'b10) $display("FAIL ack_coincident: got irq=%b ovr=%b want 1 0", irq1, ovr1); else n_pass++;
    for (int i = 0; i < 20 && tick1 !== 1'b1; i++) advance();
    n_checks++; if (tick1 !== 1'b1) $display("FAIL ack_wait_tick3: got %b want 1 (timeout)", tick1); else n_pass++;
    advance();
    n_checks++; if ({irq1, ovr1} !== 2'b11) $display("FAIL ack_overrun: got irq=%b ovr=%b want 1 1", irq1, ovr1); else n_pass++;
    Irq_ack = 1'b1;
    advance();
    Irq_ack = 1'b0;
    n_checks++; if ({irq1, ovr1} !== 2'b00) $display("FAIL ack_final_clear: got irq=%b ovr=%b want 0 0", irq1, ovr1); else n_pass++;
  endtask

  task automatic test_back_to_back();
    reload1 = 4'h3; reload2 = 8'h30; Prescale = 4'h0; Mode = 1'b0;
    Start = 1'b1;
    advance();
    Start = 1'b0;
    advance();
    n_checks++; if (q1 !== 4'h4) $display("FAIL b2b_pre: got %h want 4", q1); else n_pass++;
    reload1 = 4'h1;
    Start = 1'b1;
    advance();
    Start = 1'b0;
    n_checks++; if (q1 !== 4'h1 || busy1 !== 1'b1) $display("FAIL b2b_restart: got q=%h busy=%b want q=1 busy=1", q1, busy1); else n_pass++;
    repeat (4) advance();
    n_checks++; if (q1 !== 4'h5) $display("FAIL b2b_reach5: got %h want 5", q1); else n_pass++;
  endtask

  task automatic test_start_stop();
    reload1 = 4'hA; reload2 = 8'hA0;
    Start = 1'b1; Stop = 1'b1;
    advance();
    Start = 1'b0; Stop = 1'b0;
    n_checks++; if (q1 !== 4'h5 || busy1 !== 1'b0) $display("FAIL stopwin: got q=%h busy=%b want q=5 busy=0", q1, busy1); else n_pass++;
    repeat (3) advance();
    n_checks++; if (q1 !== 4'h5 || tick1 !== 1'b0) $display("FAIL stop_hold: got q=%h tick=%b want q=5 tick=0", q1, tick1); else n_pass++;
    Start = 1'b1;
    advance();
    Start = 1'b0;
    n_checks++; if (q1 !== 4'hA || busy1 !== 1'b1) $display("FAIL start_after_stop: got q=%h busy=%b want q=a busy=1", q1, busy1); else n_pass++;
    Stop = 1'b1;
    advance();
    Stop = 1'b0;
    n_checks++; if (q1 !== 4'hA || busy1 !== 1'b0) $display("FAIL stop_alone: got q=%h busy=%b want q=a busy=0", q1, busy1); else n_pass++;
  endtask

  task automatic test_clear();
    reload1 = 4'hD; reload2 = 8'hFD; Prescale = 4'h0; Mode = 1'b0;
    Start = 1'b1;
    advance();
    Start = 1'b0;
    repeat (3) advance();
    n_checks++; if (irq1 !== 1'b1 || busy1 !== 1'b0) $display("FAIL clear_setup_irq: got irq=%b busy=%b want 1 0", irq1, busy1); else n_pass++;
    reload1 = 4'h6;
    Start = 1'b1;
    advance();
    Start = 1'b0;
    repeat (3) advance();
    n_checks++; if (q1 !== 4'h9) $display("FAIL clear_setup_q: got %h want 9", q1); else n_pass++;
    #2 Clear = 1'b1;
    #1;
    n_checks++; if ({q1, busy1, irq1, ovr1} !== {4'h0, 3'b000}) $display("FAIL clear_async: got q=%h busy=%b irq=%b ovr=%b want 0 0 0 0", q1, busy1, irq1, ovr1); else n_pass++;
    n_checks++; if ({q2, busy2, irq2} !== {8'h00, 2'b00}) $display("FAIL clear_async2: got q=%h busy=%b irq=%b want 00 0 0", q2, busy2, irq2); else n_pass++;
    model_reset();
    #1 Clear = 1'b0;
    repeat (3) advance();
    n_checks++; if (q1 !== 4'h0 || busy1 !== 1'b0) $display("FAIL clear_no_count: got q=%h busy=%b want 0 0", q1, busy1); else n_pass++;
    reload1 = 4'h2;
    Start = 1'b1;
    advance();
    Start = 1'b0;
    n_checks++; if (q1 !== 4'h2 || busy1 !== 1'b1) $display("FAIL clear_restart: got q=%h busy=%b want 2 1", q1, busy1); else n_pass++;
  endtask

  task automatic test_two_stage();
    reload1 = 4'h0; reload2 = 8'hFE; Prescale = 4'h0; Mode = 1'b1;
    Start = 1'b1;
    advance();
    Start = 1'b0;
    for (int n = 0; n < 8; n++) begin
      logic [7:0] want_q;
      want_q = (n % 2 == 1) ? 8'hFF : 8'hFE;
      n_checks++; if (q2 !== want_q) $display("FAIL stage2_q[%0d]: got %h want %h", n, q2, want_q); else n_pass++;
      n_checks++; if (tick2 !== (n % 2 == 1)) $display("FAIL stage2_tick[%0d]: got %b want %b", n, tick2, n % 2 == 1); else n_pass++;
      advance();
    end
    reload2 = 8'h0E; Mode = 1'b0;
    Start = 1'b1;
    advance();
    Start = 1'b0;
    advance();
    n_checks++; if (q2 !== 8'h0F) $display("FAIL stage2_pre_carry: got %h want 0f", q2); else n_pass++;
    advance();
    n_checks++; if (q2 !== 8'h10) $display("FAIL stage2_carry: got %h want 10", q2); else n_pass++;
    advance();
    n_checks++; if (q2 !== 8'h11) $display("FAIL stage2_post_carry: got %h want 11", q2); else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      Start    = ($urandom_range(0, 11) == 0);
      Stop     = ($urandom_range(0, 29) == 0);
      Irq_ack  = ($urandom_range(0, 5) == 0);
      Mode     = 1'($urandom_range(0, 1));
      Prescale = 4'($urandom_range(0, 3));
      reload1  = 4'($urandom_range(0, 15));
      reload2  = 8'hF0 | 8'($urandom_range(0, 15));
      for (int d = 0; d < 2; d++) begin
        logic [7:0] oq;
        logic       ob, ot, oi, oo;
        oq = (d == 0) ? {4'h0, q1} : q2;
        ob = (d == 0) ? busy1 : busy2;
        ot = (d == 0) ? tick1 : tick2;
        oi = (d == 0) ? irq1 : irq2;
        oo = (d == 0) ? ovr1 : ovr2;
        n_checks++; if (oq !== 8'(exp_q(d))) $display("FAIL rand_q dut%0d cyc %0d: got %h want %h", d, c, oq, 8'(exp_q(d))); else n_pass++;
        n_checks++; if (ob !== (m_state[d] == 1)) $display("FAIL rand_busy dut%0d cyc %0d: got %b want %b", d, c, ob, m_state[d] == 1); else n_pass++;
        n_checks++; if (ot !== exp_tick(d)) $display("FAIL rand_tick dut%0d cyc %0d: got %b want %b", d, c, ot, exp_tick(d)); else n_pass++;
        n_checks++; if (oi !== m_irq[d]) $display("FAIL rand_irq dut%0d cyc %0d: got %b want %b", d, c, oi, m_irq[d]); else n_pass++;
        n_checks++; if (oo !== m_ovr[d]) $display("FAIL rand_ovr dut%0d cyc %0d: got %b want %b", d, c, oo, m_ovr[d]); else n_pass++;
      end
      advance();
    end
    Start = 0; Stop = 0; Irq_ack = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_oneshot();
    test_autoreload();
    test_irq_ack();
    test_back_to_back();
    test_start_stop();
    test_clear();
    test_two_stage();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ttl_timer_ctrl.md
# ttl_timer_ctrl

Programmable interval timer controller built from cascaded 4-bit synchronous up-counter stages with ripple-carry chaining. It captures a reload value, prescale ratio and mode on a start request. It then sequences load and count-enable for the counter chain, detects terminal count, and raises a latched interrupt. It sits beside the CPU bus decode as the system tick and delay source.

## Interface
- STAGES, 4, number of cascaded 4-bit stages; counter width W = 4*STAGES
- PRESCALE_WIDTH, 4, width of prescale ratio input
- Clk  input  1  clock; all state changes on rising edge
- Clear  input  1  asynchronous, active-high reset
- Start  input  1  sampled each edge; (re)arms timer
- Stop  input  1  sampled each edge; halts timer
- Mode  input  1  0 = one-shot, 1 = auto-reload; captured at Start
- Reload  input  W  initial/reload count; captured at Start
- Prescale  input  PRESCALE_WIDTH  count enable every Prescale+1 cycles; captured at Start
- Irq_ack  input  1  clears Irq and Overrun
- Q  output  W  current count
- Busy  output  1  high in RUN
- Tick  output  1  combinational terminal-count pulse, one cycle
- Irq  output  1  latched expiry interrupt
- Overrun  output  1  expiry occurred while Irq already set

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: Q = 0, Busy = 0, Irq = 0, Overrun = 0, prescaler = 0. Tick = 0 because the state is not RUN.
- Start in any state:
  - Q <= Reload; shadow Mode, Reload and Prescale are loaded; prescaler <= 0; next state RUN.
  - Start in RUN restarts the count.
- Stop in RUN: next state IDLE; Q holds. Stop in IDLE or DONE: no effect.
- Start and Stop in the same cycle: Stop wins, and no load occurs.
- In RUN the prescaler increments each cycle. en = (prescaler == shadow Prescale). When en is high, prescaler <= 0.
- When en is high, Q increments through the counter chain. The enable is chained through stage carries in the same way as a count enable into a ripple-carry cascade.
- Tick = RUN & en & (Q == all ones).
- On Tick:
  - Auto-reload: Q <= shadow Reload, stay in RUN.
  - One-shot: Q holds at all ones, next state DONE.
- Irq set/clear:
  - Irq <= 1 on Tick.
  - Irq_ack clears it.
  - Tick and Irq_ack in the same cycle: Irq stays 1 (set wins).
- Overrun set/clear:
  - Overrun <= 1 on Tick while Irq == 1 and Irq_ack == 0.
  - Overrun is cleared only by Irq_ack.
- Changes to Mode, Reload or Prescale while in RUN are ignored until the next Start.
- Reload = all ones: expiry on the first en pulse.

## Timing
- Start sampled at edge k: Q = Reload and Busy = 1 after edge k.
- With prescale value P, the first increment occurs at edge k+P+1.
- Expiry latency from Start: (2^W − Reload)·(P+1) cycles. Auto-reload period is the same value.
- Tick is high during the cycle before the expiry edge. Irq is visible after that edge.
- One-shot: Busy falls at the expiry edge.
- Clear asserted mid-count forces all reset values immediately, independent of Clk.
- Count resumes only on a Start sampled after Clear deasserts.

## Structure
- Shared package timer_pkg holds:
  - state encoding constants ST_IDLE, ST_RUN, ST_DONE
  - mode constants MODE_ONESHOT = 0, MODE_RELOAD = 1
- Sub-module counter_stage4 is a 4-bit loadable up-counter with ENT/ENP inputs, RCO output and async clear.
- The controller instantiates STAGES copies, chaining RCO of each stage into ENT of the next.
- The controller holds the FSM, prescaler, shadow registers and Irq/Overrun logic.

## Test plan
All scenarios use STAGES=1 unless noted.
- One-shot, Reload=4'hC, Prescale=0, Start at edge 0:
  - Q = C, D, E, F after edges 0–3.
  - Tick high between edges 3 and 4.
  - After edge 4: Irq=1, Busy=0, Q=F, and Q stays F.
- Auto-reload, Reload=4'hE, Prescale=1:
  - Q holds each value for 2 cycles.
  - Tick every 4 cycles.
  - Q wraps F→E, never reaching 0.
- Tick coincident with Irq_ack while Irq=1: Irq stays 1, Overrun stays 0. A second Tick with no ack sets Overrun=1.
- Start and Stop together in RUN at Q=5: state goes to IDLE, Q stays 5, Busy=0. A later Start alone reloads Reload.
- Clear pulsed asynchronously mid-RUN at Q=9: Q=0, Busy=0, Irq=0 before the next Clk edge. No counting occurs until Start.
- STAGES=2, Reload=8'hFE, Prescale=0, auto-reload: carry crosses stages correctly, and Tick occurs every 2 cycles.
